// File: rtl/mii_pkg.sv
// Definitions shared by the MII nibble transmit and receive cores:
// frame state encoding, framing constants and the nibble bit-mirror helpers.
package mii_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      IFG
   } mii_state_e;

   localparam logic [7:0] PREAMBLE_BYTE    = 8'h55;
   localparam logic [7:0] DEFAULT_SFD_BYTE = 8'hD5;

   // The receiver shifts nibbles in MSB-first, so each nibble goes out mirrored.
   function automatic logic [3:0] nibble_reverse(input logic [3:0] n);
      return {n[0], n[1], n[2], n[3]};
   endfunction

   function automatic logic [3:0] byte_nibble(input logic [7:0] b, input logic hi);
      return nibble_reverse(hi ? b[7:4] : b[3:0]);
   endfunction

endpackage

// File: rtl/mii_tx_core.sv
// MII transmit framer: wraps a valid/ready byte stream in preamble, SFD and an
// inter-frame gap, serialising each byte low nibble first onto TXD.
module mii_tx_core
   import mii_pkg::*;
#(
   parameter int unsigned PREAMBLE_BYTES = 7,
   parameter logic [7:0]  SFD_BYTE       = DEFAULT_SFD_BYTE,
   parameter int unsigned IFG_NIBBLES    = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic       busy,
   output logic       error,
   output logic       mii_en,
   output logic       mii_er,
   output logic [3:0] mii_d
);

   localparam logic [4:0] PRE_NIBBLES = 5'(2 * PREAMBLE_BYTES);
   localparam logic [7:0] IFG_LOAD    = 8'(IFG_NIBBLES);
   localparam logic [3:0] PRE_NIBBLE  = byte_nibble(PREAMBLE_BYTE, 1'b0);

   mii_state_e state_q, state_d;
   logic [4:0] pre_cnt_q, pre_cnt_d;
   logic [7:0] ifg_cnt_q, ifg_cnt_d;
   logic       sfd_q, sfd_d;
   logic       phase_q, phase_d;
   logic       last_q, last_d;
   logic [7:0] byte_q, byte_d;
   logic       en_q, en_d;
   logic       er_q, er_d;
   logic       err_q, err_d;
   logic [3:0] d_q, d_d;
   logic       take_byte;

   // A byte is requested while the SFD high nibble or a non-final high nibble is on the wire.
   assign s_ready = reset & (((state_q == PREAMBLE) & sfd_q & phase_q) |
                             ((state_q == DATA) & phase_q & ~last_q));
   assign busy    = (state_q != IDLE);
   assign error   = err_q;
   assign mii_en  = en_q;
   assign mii_er  = er_q;
   assign mii_d   = d_q;

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      ifg_cnt_d = ifg_cnt_q;
      sfd_d     = sfd_q;
      phase_d   = phase_q;
      last_d    = last_q;
      byte_d    = byte_q;
      en_d      = 1'b0;
      er_d      = 1'b0;
      err_d     = 1'b0;
      d_d       = 4'h0;
      take_byte = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (s_valid) begin
               state_d   = PREAMBLE;
               pre_cnt_d = PRE_NIBBLES;
               sfd_d     = 1'b0;
               phase_d   = 1'b0;
               en_d      = 1'b1;
               d_d       = PRE_NIBBLE;
            end
         end
         PREAMBLE: begin
            en_d = 1'b1;
            if (!sfd_q) begin
               if (pre_cnt_q == 5'd1) begin
                  sfd_d   = 1'b1;
                  phase_d = 1'b0;
                  d_d     = byte_nibble(SFD_BYTE, 1'b0);
               end else begin
                  pre_cnt_d = pre_cnt_q - 5'd1;
                  d_d       = PRE_NIBBLE;
               end
            end else if (!phase_q) begin
               phase_d = 1'b1;
               d_d     = byte_nibble(SFD_BYTE, 1'b1);
            end else begin
               take_byte = 1'b1;
            end
         end
         DATA: begin
            if (!phase_q) begin
               phase_d = 1'b1;
               en_d    = 1'b1;
               d_d     = byte_nibble(byte_q, 1'b1);
            end else if (last_q) begin
               state_d   = IFG;
               ifg_cnt_d = IFG_LOAD;
            end else begin
               take_byte = 1'b1;
            end
         end
         IFG: begin
            // The underrun nibble occupies the first IFG cycle and is not counted.
            if (!err_q) begin
               if (ifg_cnt_q == 8'd1) begin
                  state_d = IDLE;
               end else begin
                  ifg_cnt_d = ifg_cnt_q - 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (take_byte) begin
         if (s_valid) begin
            state_d = DATA;
            byte_d  = s_data;
            last_d  = s_last;
            phase_d = 1'b0;
            en_d    = 1'b1;
            d_d     = byte_nibble(s_data, 1'b0);
         end else begin
            state_d   = IFG;
            ifg_cnt_d = IFG_LOAD;
            en_d      = 1'b1;
            er_d      = 1'b1;
            err_d     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         pre_cnt_q <= 5'd0;
         ifg_cnt_q <= 8'd0;
         sfd_q     <= 1'b0;
         phase_q   <= 1'b0;
         last_q    <= 1'b0;
         byte_q    <= 8'h00;
         en_q      <= 1'b0;
         er_q      <= 1'b0;
         err_q     <= 1'b0;
         d_q       <= 4'h0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         ifg_cnt_q <= ifg_cnt_d;
         sfd_q     <= sfd_d;
         phase_q   <= phase_d;
         last_q    <= last_d;
         byte_q    <= byte_d;
         en_q      <= en_d;
         er_q      <= er_d;
         err_q     <= err_d;
         d_q       <= d_d;
      end
   end

endmodule

// File: tb/tb_mii_tx_core.sv
// Self-checking bench for mii_tx_core: expected wire traces are built from the
// framing rules (preamble, SFD, mirrored nibbles, underrun nibble, IFG) and compared cycle by cycle.
module tb_mii_tx_core;

   typedef struct packed {
      logic       en;
      logic       er;
      logic [3:0] d;
      logic       err;
      logic       busy;
      logic       rdy;
      logic       acc;
   } sample_t;

   typedef struct {
      logic [7:0] b;
      logic [3:0] lo;
      logic [3:0] hi;
   } vec_t;

   localparam logic [9:0] CMP_MASK = 10'h3FE;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready, busy, error, mii_en, mii_er;
   logic [3:0] mii_d;
   logic       smReady, smBusy, smError, smEn, smEr;
   logic [3:0] smD;
   logic       curReady, curBusy;

   bit         useSmall = 1'b0;
   bit         recording = 1'b0;
   sample_t    trace[$];
   sample_t    expQ[$];
   logic [7:0] txBytes[$];
   bit         txLast[$];
   int         checks = 0;
   int         errors = 0;
   int         lastStart = -1;

   always #5 clk = ~clk;

   mii_tx_core dut (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .busy(busy), .error(error),
      .mii_en(mii_en), .mii_er(mii_er), .mii_d(mii_d)
   );

   mii_tx_core #(.PREAMBLE_BYTES(1), .IFG_NIBBLES(1)) dutSmall (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(smReady), .busy(smBusy), .error(smError),
      .mii_en(smEn), .mii_er(smEr), .mii_d(smD)
   );

   assign curReady = useSmall ? smReady : s_ready;
   assign curBusy  = useSmall ? smBusy  : busy;

   // Record the selected DUT's outputs once per cycle, away from the active edge.
   always @(negedge clk) begin
      sample_t s;
      if (recording) begin
         if (useSmall) s = {smEn, smEr, smD, smError, smBusy, smReady, smReady & s_valid};
         else          s = {mii_en, mii_er, mii_d, error, busy, s_ready, s_ready & s_valid};
         trace.push_back(s);
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkValue(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic [3:0] mirror(input logic [3:0] n);
      logic [3:0] r;
      for (int k = 0; k < 4; k++) r[3 - k] = n[k];
      return r;
   endfunction

   function automatic sample_t mk(input logic en, input logic er, input logic [3:0] d,
                                  input logic err, input logic bsy, input logic rdy);
      return {en, er, d, err, bsy, rdy, 1'b0};
   endfunction

   // Expected wire activity from the first preamble nibble, for the bytes the source offers.
   function automatic void buildExpected(input int pb, input int ifg, input int stopAt);
      logic [7:0] sfd = 8'hD5;
      logic [7:0] b;
      int i = 0;
      bit complete;
      expQ.delete();
      while (i < stopAt) begin
         repeat (2 * pb) expQ.push_back(mk(1, 0, mirror(4'h5), 0, 1, 0));
         expQ.push_back(mk(1, 0, mirror(sfd[3:0]), 0, 1, 0));
         expQ.push_back(mk(1, 0, mirror(sfd[7:4]), 0, 1, 1));
         complete = 1'b0;
         while (1) begin
            b = txBytes[i];
            expQ.push_back(mk(1, 0, mirror(b[3:0]), 0, 1, 0));
            expQ.push_back(mk(1, 0, mirror(b[7:4]), 0, 1, !txLast[i]));
            i++;
            if (txLast[i - 1]) begin
               complete = 1'b1;
               break;
            end
            if (i == stopAt) break;
         end
         if (!complete) expQ.push_back(mk(1, 1, 4'h0, 1, 1, 0));
         repeat (ifg) expQ.push_back(mk(0, 0, 4'h0, 0, 1, 0));
         if (complete && i < stopAt) expQ.push_back(mk(0, 0, 4'h0, 0, 0, 0));
      end
      expQ.push_back(mk(0, 0, 4'h0, 0, 0, 0));
   endfunction

   // Offer txBytes with valid held continuously; drop valid after stopAt bytes are accepted.
   task automatic applyStimulus(input int stopAt);
      int idx = 0;
      int guard = 0;
      bit acc;
      trace.delete();
      recording = 1'b1;
      s_valid = 1'b1;
      s_data  = txBytes[0];
      s_last  = txLast[0];
      while (idx < stopAt && guard < 1000) begin
         @(negedge clk);
         acc = curReady && s_valid;
         @(posedge clk);
         #1;
         guard++;
         if (acc) begin
            idx++;
            if (idx < stopAt) begin
               s_data = txBytes[idx];
               s_last = txLast[idx];
            end else begin
               s_valid = 1'b0;
               s_last  = 1'b0;
               s_data  = 8'h00;
            end
         end
      end
      checkValue("driverBytesAccepted", idx, stopAt);
   endtask

   task automatic waitIdle(input string name);
      int c = 0;
      while (curBusy && c < 3000) begin
         @(negedge clk);
         c++;
      end
      if (curBusy) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_idleTimeout: busy=%0d after %0d cycles, expected 0", name, curBusy, c);
      end
      @(negedge clk);
      @(posedge clk);
      #1;
      recording = 1'b0;
   endtask

   task automatic checkOutput(input string name, input int pb, input int ifg, input int stopAt);
      int bad = -1;
      int nAcc = 0;
      buildExpected(pb, ifg, stopAt);
      lastStart = -1;
      foreach (trace[k]) if (lastStart < 0 && trace[k].en) lastStart = k;
      checkValue({name, "_frameSeen"}, int'(lastStart >= 0), 1);
      foreach (trace[k]) if (trace[k].acc) nAcc++;
      checkValue({name, "_bytesTaken"}, nAcc, stopAt);
      if (lastStart >= 0) begin
         checks++;
         if (trace.size() < lastStart + expQ.size()) begin
            errors++;
            $display("[TB] FAIL %s_traceLength: got %0d cycles, expected at least %0d",
                     name, trace.size() - lastStart, expQ.size());
         end else begin
            for (int k = 0; k < expQ.size(); k++)
               if (bad < 0 && ((trace[lastStart + k] & CMP_MASK) != expQ[k])) bad = k;
            if (bad >= 0) begin
               errors++;
               $display("[TB] FAIL %s_trace: cycle %0d en,er,d,err,busy,rdy got %b expected %b",
                        name, bad, trace[lastStart + bad][9:1], expQ[bad][9:1]);
            end
         end
      end
   endtask

   initial begin
      vec_t vecs[6];
      int   rdyIdx[$];
      int   fall, rise, nErr, nFrames, len, frameStart, stopAt, c;

      vecs[0] = '{8'h3C, 4'h3, 4'hC};
      vecs[1] = '{8'h01, 4'h8, 4'h0};
      vecs[2] = '{8'h80, 4'h0, 4'h1};
      vecs[3] = '{8'hFF, 4'hF, 4'hF};
      vecs[4] = '{8'hA7, 4'hE, 4'h5};
      vecs[5] = '{8'h12, 4'h4, 4'h8};

      reset = 1'b0;
      s_valid = 1'b0;
      s_last = 1'b0;
      s_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkValue("resetEn", mii_en, 0);
      checkValue("resetEr", mii_er, 0);
      checkValue("resetD", mii_d, 0);
      checkValue("resetError", error, 0);
      checkValue("resetBusy", busy, 0);
      checkValue("resetReady", s_ready, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single-byte frames from the table: full trace plus hand-computed data nibbles.
      foreach (vecs[v]) begin
         txBytes = {vecs[v].b};
         txLast  = {1'b1};
         applyStimulus(1);
         waitIdle("vec");
         checkOutput("vec", 7, 24, 1);
         if (lastStart >= 0 && trace.size() > lastStart + 17) begin
            checkValue("vecLoNibble", trace[lastStart + 16].d, vecs[v].lo);
            checkValue("vecHiNibble", trace[lastStart + 17].d, vecs[v].hi);
         end
      end

      // Three bytes: s_ready exactly three times, two cycles apart.
      txBytes = {8'h01, 8'h80, 8'hFF};
      txLast  = {1'b0, 1'b0, 1'b1};
      applyStimulus(3);
      waitIdle("three");
      checkOutput("three", 7, 24, 3);
      rdyIdx.delete();
      foreach (trace[k]) if (trace[k].rdy) rdyIdx.push_back(k);
      checkValue("threeReadyCount", rdyIdx.size(), 3);
      if (rdyIdx.size() == 3) begin
         checkValue("threeReadySpacing1", rdyIdx[1] - rdyIdx[0], 2);
         checkValue("threeReadySpacing2", rdyIdx[2] - rdyIdx[1], 2);
      end

      // Underrun: source stops before its last byte.
      txBytes = {8'hA1, 8'hB2};
      txLast  = {1'b0, 1'b1};
      applyStimulus(1);
      waitIdle("underrun");
      checkOutput("underrun", 7, 24, 1);
      nErr = 0;
      foreach (trace[k]) if (trace[k].err) nErr++;
      checkValue("underrunErrorPulses", nErr, 1);

      // Back-to-back frames with valid held across the gap.
      txBytes = {8'h21, 8'h43, 8'h65};
      txLast  = {1'b0, 1'b1, 1'b1};
      applyStimulus(3);
      waitIdle("b2b");
      checkOutput("b2b", 7, 24, 3);
      fall = -1;
      rise = -1;
      if (lastStart >= 0) begin
         for (int k = lastStart; k < trace.size(); k++) begin
            if (fall < 0 && !trace[k].en) fall = k;
            else if (fall >= 0 && rise < 0 && trace[k].en) rise = k;
         end
      end
      checkValue("b2bGap", rise - fall, 25);

      // Reset pulse during DATA, with the source still presenting a byte.
      s_valid = 1'b1;
      s_data  = 8'h11;
      s_last  = 1'b0;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!mii_en && c < 100);
      checkValue("resetTestFrameStarted", mii_en, 1);
      repeat (17) @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      txBytes = {8'h11};
      txLast  = {1'b1};
      applyStimulus(1);
      waitIdle("midReset");
      if (trace.size() > 0) checkValue("midResetOutputs", int'(trace[0][9:1]), 0);
      checkOutput("midReset", 7, 24, 1);
      checkValue("midResetRestartCycle", lastStart, 1);

      // Randomised frame groups against the reference model.
      for (int it = 0; it < 8; it++) begin
         txBytes.delete();
         txLast.delete();
         nFrames = $urandom_range(1, 2);
         len = 1;
         frameStart = 0;
         for (int f = 0; f < nFrames; f++) begin
            len = $urandom_range(1, 5);
            frameStart = txBytes.size();
            for (int j = 0; j < len; j++) begin
               txBytes.push_back(8'($urandom));
               txLast.push_back(j == len - 1);
            end
         end
         stopAt = txBytes.size();
         if (len >= 2 && $urandom_range(0, 3) == 0) stopAt = frameStart + $urandom_range(1, len - 1);
         applyStimulus(stopAt);
         waitIdle("random");
         checkOutput("random", 7, 24, stopAt);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
      end

      // Minimum preamble and gap on the second instance.
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      useSmall = 1'b1;
      txBytes = {8'h3C};
      txLast  = {1'b1};
      applyStimulus(1);
      waitIdle("small");
      checkOutput("small", 1, 1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
